// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg: FSM state types shared by the FIFO burst tester.
package fifo_burst_pkg;
    typedef enum logic {W_IDLE, W_BURST} wr_state_t;
    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
    localparam int CNT_W = 16;
endpackage

// File: rtl/fifo_burst_tester_store.sv
// fifo_store_p: FIFO storage with extra-MSB pointers, occupancy and registered read port.
module fifo_store_p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        dout_o,
    output logic                     dout_valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic dout_valid_q;
    logic wr_acc, rd_acc;
    // Pointer MSB differs with equal low bits only when the FIFO holds DEPTH words.
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = wr_ptr_q == rd_ptr_q;
    assign level_o  = wr_ptr_q - rd_ptr_q;
    assign wr_acc   = wr_en_i && !full_o;
    assign rd_acc   = rd_en_i && !empty_o;
    assign wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign dout_d   = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : dout_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= rd_acc;
        end
    end
endmodule

// File: rtl/fifo_burst_tester.sv
// fifo_burst_tester: burst writer, burst reader and in-order checker around fifo_store_p.
// Define FIFO_ALMOST_EN to add the almost_full/almost_empty outputs.
module fifo_burst_tester
    import fifo_burst_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 16,
    parameter int BURST_LEN     = 8,
    parameter int ALMOST_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_write,
    input  logic                   start_read,
    output logic [DATA_W-1:0]      dout,
    output logic                   dout_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   wr_busy,
    output logic                   rd_busy,
    output logic                   err
`ifdef FIFO_ALMOST_EN
    ,
    output logic                   almost_full,
    output logic                   almost_empty
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;
    if (DEPTH < 2 || BURST_LEN < 1 || ALMOST_MARGIN >= DEPTH / 2) begin : g_bad_cfg
        $error("fifo_burst_tester: invalid parameters");
    end
    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic [CNT_W-1:0] wr_rem_q, wr_rem_d, rd_rem_q, rd_rem_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, exp_q, exp_d;
    logic err_q, err_d;
    logic wr_en, rd_en;
    fifo_store_p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_store (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data_q),
        .rd_en_i      (rd_en),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .full_o       (full),
        .empty_o      (empty),
        .level_o      (level)
    );
    assign wr_busy = wr_state_q == W_BURST;
    assign rd_busy = rd_state_q == R_BURST;
    assign wr_en   = wr_busy && !full;
    assign rd_en   = rd_busy && !empty;
    assign err     = err_q;
    always_comb begin
        wr_state_d = wr_state_q;
        wr_rem_d   = wr_rem_q;
        wr_data_d  = wr_data_q;
        if (!wr_busy) begin
            if (start_write) begin
                wr_state_d = W_BURST;
                wr_rem_d   = CNT_W'(BURST_LEN);
            end
        end else if (wr_en) begin
            wr_data_d  = wr_data_q + 1'b1;
            wr_rem_d   = wr_rem_q - 1'b1;
            wr_state_d = wr_rem_q == 1 ? W_IDLE : W_BURST;
        end
    end
    always_comb begin
        rd_state_d = rd_state_q;
        rd_rem_d   = rd_rem_q;
        if (!rd_busy) begin
            if (start_read) begin
                rd_state_d = R_BURST;
                rd_rem_d   = CNT_W'(BURST_LEN);
            end
        end else if (rd_en) begin
            rd_rem_d   = rd_rem_q - 1'b1;
            rd_state_d = rd_rem_q == 1 ? R_IDLE : R_BURST;
        end
    end
    assign exp_d = dout_valid ? exp_q + 1'b1 : exp_q;
    assign err_d = err_q || (dout_valid && dout != exp_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_rem_q   <= '0;
            rd_rem_q   <= '0;
            wr_data_q  <= '0;
            exp_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_rem_q   <= wr_rem_d;
            rd_rem_q   <= rd_rem_d;
            wr_data_q  <= wr_data_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
        end
    end
`ifdef FIFO_ALMOST_EN
    assign almost_full  = level >= LW'(DEPTH - ALMOST_MARGIN);
    assign almost_empty = level <= LW'(ALMOST_MARGIN);
`endif
endmodule

// File: tb/tb_fifo_burst_tester.sv
// tb_fifo_burst_tester: directed burst scenarios with in-order data checking.
module tb_fifo_burst_tester;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_write = 1'b0;
    logic start_read = 1'b0;
    logic [7:0] dout;
    logic dout_valid, full, empty, wr_busy, rd_busy, err;
    logic [4:0] level;
`ifdef FIFO_ALMOST_EN
    logic almost_full, almost_empty;
`endif
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_tb = '0;

    always #5 clk = ~clk;

    fifo_burst_tester #(.DATA_W(8), .DEPTH(16), .BURST_LEN(8), .ALMOST_MARGIN(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_write  (start_write),
        .start_read   (start_read),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .wr_busy      (wr_busy),
        .rd_busy      (rd_busy),
        .err          (err)
`ifdef FIFO_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every popped word must follow the running counter from the last reset.
    task automatic tick();
        @(posedge clk);
        #1;
        if (dout_valid === 1'b1) begin
            chk("dout", 32'(dout), 32'(exp_tb));
            exp_tb++;
        end
    endtask

    task automatic pulse(input logic w, input logic r);
        start_write = w;
        start_read  = r;
        tick();
        start_write = 1'b0;
        start_read  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_write = 1'b0;
        start_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tb = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (wr_busy || rd_busy); i++) tick();
        chk("idle", 32'({wr_busy, rd_busy}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'({wr_busy, rd_busy}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
`ifdef FIFO_ALMOST_EN
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
`endif
        // 1: single write burst then single read burst
        pulse(1'b1, 1'b0);
        repeat (7) tick();
        chk("t1_level7", 32'(level), 32'd7);
        chk("t1_wbusy7", 32'(wr_busy), 32'd1);
        tick();
        chk("t1_level", 32'(level), 32'd8);
        chk("t1_wbusy", 32'(wr_busy), 32'd0);
        pulse(1'b0, 1'b1);
        chk("t1_rbusy", 32'(rd_busy), 32'd1);
        repeat (8) tick();
        chk("t1_nwords", 32'(exp_tb), 32'd8);
        tick();
        chk("t1_hold", 32'(dout), 32'd7);
        chk("t1_valid0", 32'(dout_valid), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        // 2: fill to full, stalled third burst, resume on reads
        pulse(1'b1, 1'b0);
        repeat (8) tick();
        pulse(1'b1, 1'b0);
        repeat (8) tick();
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_level", 32'(level), 32'd16);
        pulse(1'b1, 1'b0);
        repeat (5) tick();
        chk("t2_stall_level", 32'(level), 32'd16);
        chk("t2_stall_busy", 32'(wr_busy), 32'd1);
        pulse(1'b0, 1'b1);
        wait_idle();
        chk("t2_level_after", 32'(level), 32'd16);
        pulse(1'b0, 1'b1);
        wait_idle();
        pulse(1'b0, 1'b1);
        wait_idle();
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_nwords", 32'(exp_tb), 32'd32);
        chk("t2_err", 32'(err), 32'd0);
        // 3: read burst started on an empty FIFO waits for the writer
        do_reset();
        pulse(1'b0, 1'b1);
        repeat (3) tick();
        chk("t3_rbusy", 32'(rd_busy), 32'd1);
        chk("t3_nopop", 32'(exp_tb), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);
        pulse(1'b1, 1'b0);
        tick();
        tick();
        chk("t3_level", 32'(level), 32'd1);
        chk("t3_valid", 32'(dout_valid), 32'd1);
        wait_idle();
        chk("t3_nwords", 32'(exp_tb), 32'd8);
        chk("t3_err", 32'(err), 32'd0);
        // 4: five overlapping write/read burst pairs
        do_reset();
        for (int b = 0; b < 5; b++) begin
            pulse(1'b1, 1'b1);
            tick();
            tick();
            chk("t4_level1", 32'(level), 32'd1);
            wait_idle();
            chk("t4_level0", 32'(level), 32'd0);
        end
        chk("t4_nwords", 32'(exp_tb), 32'd40);
        chk("t4_err", 32'(err), 32'd0);
        // 5: reset in the middle of a burst
        do_reset();
        pulse(1'b1, 1'b0);
        repeat (5) tick();
        chk("t5_level5", 32'(level), 32'd5);
        chk("t5_wbusy", 32'(wr_busy), 32'd1);
        do_reset();
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_busy", 32'({wr_busy, rd_busy}), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_valid", 32'(dout_valid), 32'd0);
        pulse(1'b1, 1'b0);
        wait_idle();
        pulse(1'b0, 1'b1);
        wait_idle();
        chk("t5_nwords", 32'(exp_tb), 32'd8);
        chk("t5_err_end", 32'(err), 32'd0);
`ifdef FIFO_ALMOST_EN
        // 6: almost flag thresholds
        do_reset();
        pulse(1'b1, 1'b0);
        repeat (2) tick();
        chk("t6_ae_l2", 32'(almost_empty), 32'd1);
        tick();
        chk("t6_ae_l3", 32'(almost_empty), 32'd0);
        repeat (5) tick();
        pulse(1'b1, 1'b0);
        repeat (5) tick();
        chk("t6_level13", 32'(level), 32'd13);
        chk("t6_af_l13", 32'(almost_full), 32'd0);
        tick();
        chk("t6_af_l14", 32'(almost_full), 32'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
